// File: rtl/mc_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: ALU codes, opcodes,
// R-type funct values, datapath mux selects and FSM states.
package mc_control_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOR = 3'd5,
    ALU_SLT = 3'd6
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_ALU_WB,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic       SRC_A_PC   = 1'b0;
  localparam logic       SRC_A_REG  = 1'b1;
  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;
  localparam logic [1:0] SRC_B_BR   = 2'b11;

  localparam logic [1:0] PC_SRC_ALU = 2'b00;
  localparam logic [1:0] PC_SRC_OUT = 2'b01;
  localparam logic [1:0] PC_SRC_JMP = 2'b10;

endpackage

// File: rtl/mc_control_alu_decoder.sv
// Combinational opcode/funct to ALU operation decode, plus a legal flag for
// anything the control unit does not implement.
module mc_control_alu_decoder
  import mc_control_pkg::*;
#(
  parameter int unsigned FUNC_W = 11
) (
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  output logic [FUNC_W-1:0] alu_func,
  output logic              legal
);

  alu_op_e op;

  always_comb begin
    op    = ALU_ADD;
    legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  op = ALU_ADD;
          FN_SUB:  op = ALU_SUB;
          FN_AND:  op = ALU_AND;
          FN_OR:   op = ALU_OR;
          FN_XOR:  op = ALU_XOR;
          FN_NOR:  op = ALU_NOR;
          FN_SLT:  op = ALU_SLT;
          default: legal = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI, OP_J: op = ALU_ADD;
      OP_BEQ, OP_BNE:              op = ALU_SUB;
      OP_ANDI:                     op = ALU_AND;
      OP_ORI:                      op = ALU_OR;
      default:                     legal = 1'b0;
    endcase
  end

  assign alu_func = FUNC_W'(op);

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/write-back and driving datapath selects, enables and the ALU code.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int unsigned FUNC_W = 11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_instr,
  input  logic              i_zero,
  input  logic              i_mem_ready,
  output logic [FUNC_W-1:0] o_alu_func,
  output logic              o_alu_src_a,
  output logic [1:0]        o_alu_src_b,
  output logic              o_ext_zero,
  output logic              o_pc_write,
  output logic [1:0]        o_pc_src,
  output logic              o_ir_write,
  output logic              o_i_or_d,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_reg_write,
  output logic              o_reg_dst,
  output logic              o_mem_to_reg,
  output logic              o_illegal
);

  state_e            state, state_nxt;
  logic [5:0]        opcode, funct;
  logic [FUNC_W-1:0] dec_func;
  logic              dec_legal;
  logic              unused_instr;

  assign opcode       = i_instr[31:26];
  assign funct        = i_instr[5:0];
  assign unused_instr = ^i_instr[25:6];

  mc_control_alu_decoder #(.FUNC_W(FUNC_W)) u_alu_decoder (
    .opcode   (opcode),
    .funct    (funct),
    .alu_func (dec_func),
    .legal    (dec_legal)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Outputs are forced low while reset is held so an aborted access never strobes.
  always_comb begin
    state_nxt    = state;
    o_alu_func   = FUNC_W'(ALU_ADD);
    o_alu_src_a  = SRC_A_PC;
    o_alu_src_b  = SRC_B_REG;
    o_ext_zero   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = PC_SRC_ALU;
    o_ir_write   = 1'b0;
    o_i_or_d     = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_reg_write  = 1'b0;
    o_reg_dst    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_illegal    = 1'b0;
    if (!i_rst) begin
      case (state)
        S_FETCH: begin
          o_mem_read  = 1'b1;
          o_alu_src_b = SRC_B_FOUR;
          if (i_mem_ready) begin
            o_ir_write = 1'b1;
            o_pc_write = 1'b1;
            state_nxt  = S_DECODE;
          end
        end
        S_DECODE: begin
          o_alu_src_b = SRC_B_BR;
          if (opcode == OP_J) begin
            o_pc_src   = PC_SRC_JMP;
            o_pc_write = 1'b1;
            state_nxt  = S_FETCH;
          end else if (!dec_legal) begin
            state_nxt = S_TRAP;
          end else begin
            state_nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          // Register A is the first operand for address, immediate and compare alike.
          o_alu_func  = dec_func;
          o_alu_src_a = SRC_A_REG;
          case (opcode)
            OP_RTYPE: begin
              o_alu_src_b = SRC_B_REG;
              state_nxt   = S_ALU_WB;
            end
            OP_LW: begin
              o_alu_src_b = SRC_B_IMM;
              state_nxt   = S_MEM_RD;
            end
            OP_SW: begin
              o_alu_src_b = SRC_B_IMM;
              state_nxt   = S_MEM_WR;
            end
            OP_ADDI: begin
              o_alu_src_b = SRC_B_IMM;
              state_nxt   = S_ALU_WB;
            end
            OP_ANDI, OP_ORI: begin
              o_alu_src_b = SRC_B_IMM;
              o_ext_zero  = 1'b1;
              state_nxt   = S_ALU_WB;
            end
            OP_BEQ, OP_BNE: begin
              o_alu_src_b = SRC_B_REG;
              o_pc_src    = PC_SRC_OUT;
              o_pc_write  = (opcode == OP_BEQ) ? i_zero : !i_zero;
              state_nxt   = S_FETCH;
            end
            default: state_nxt = S_TRAP;
          endcase
        end
        S_ALU_WB: begin
          o_reg_write = 1'b1;
          o_reg_dst   = (opcode == OP_RTYPE);
          state_nxt   = S_FETCH;
        end
        S_MEM_RD: begin
          o_mem_read = 1'b1;
          o_i_or_d   = 1'b1;
          if (i_mem_ready) state_nxt = S_MEM_WB;
        end
        S_MEM_WB: begin
          o_reg_write  = 1'b1;
          o_mem_to_reg = 1'b1;
          state_nxt    = S_FETCH;
        end
        S_MEM_WR: begin
          o_mem_write = 1'b1;
          o_i_or_d    = 1'b1;
          if (i_mem_ready) state_nxt = S_FETCH;
        end
        S_TRAP:  o_illegal = 1'b1;
        default: state_nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Cycle-by-cycle bench for mc_control: each driven cycle pushes the expected
// output vector into a scoreboard queue, popped and compared mid-cycle.
module tb_mc_control;

  localparam int unsigned FUNC_W = 11;

  typedef logic [25:0] vec_t;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [31:0]       i_instr = '0;
  logic              i_zero = 1'b0;
  logic              i_mem_ready = 1'b1;
  logic [FUNC_W-1:0] o_alu_func;
  logic              o_alu_src_a;
  logic [1:0]        o_alu_src_b;
  logic              o_ext_zero;
  logic              o_pc_write;
  logic [1:0]        o_pc_src;
  logic              o_ir_write;
  logic              o_i_or_d;
  logic              o_mem_read;
  logic              o_mem_write;
  logic              o_reg_write;
  logic              o_reg_dst;
  logic              o_mem_to_reg;
  logic              o_illegal;

  int unsigned checks = 0;
  int unsigned errors = 0;
  vec_t        exp_q[$];
  vec_t        outv;

  mc_control #(.FUNC_W(FUNC_W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_instr      (i_instr),
    .i_zero       (i_zero),
    .i_mem_ready  (i_mem_ready),
    .o_alu_func   (o_alu_func),
    .o_alu_src_a  (o_alu_src_a),
    .o_alu_src_b  (o_alu_src_b),
    .o_ext_zero   (o_ext_zero),
    .o_pc_write   (o_pc_write),
    .o_pc_src     (o_pc_src),
    .o_ir_write   (o_ir_write),
    .o_i_or_d     (o_i_or_d),
    .o_mem_read   (o_mem_read),
    .o_mem_write  (o_mem_write),
    .o_reg_write  (o_reg_write),
    .o_reg_dst    (o_reg_dst),
    .o_mem_to_reg (o_mem_to_reg),
    .o_illegal    (o_illegal)
  );

  always #5 i_clk = ~i_clk;

  assign outv = {o_alu_func, o_alu_src_a, o_alu_src_b, o_ext_zero, o_pc_write,
                 o_pc_src, o_ir_write, o_i_or_d, o_mem_read, o_mem_write,
                 o_reg_write, o_reg_dst, o_mem_to_reg, o_illegal};

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Field order matches outv.
  function automatic vec_t mk(input int alu, input bit sa, input bit [1:0] sb,
                              input bit ext, input bit pcw, input bit [1:0] pcs,
                              input bit irw, input bit iord, input bit mr,
                              input bit mw, input bit rw, input bit rd,
                              input bit m2r, input bit ill);
    logic [10:0] a;
    a = alu[10:0];
    return {a, sa, sb, ext, pcw, pcs, irw, iord, mr, mw, rw, rd, m2r, ill};
  endfunction

  function automatic vec_t v_fetch(input bit rdy);
    return mk(0, 0, 2'b01, 0, rdy, 2'b00, rdy, 0, 1, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t v_decode(input bit jmp);
    return mk(0, 0, 2'b11, 0, jmp, jmp ? 2'b10 : 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t v_exec(input int alu, input bit [1:0] sb, input bit ext);
    return mk(alu, 1, sb, ext, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t v_alu_wb(input bit rd);
    return mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, rd, 0, 0);
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic drive(input vec_t exp, input logic rdy, input logic z, input string tag);
    i_mem_ready = rdy;
    i_zero      = z;
    exp_q.push_back(exp);
    @(negedge i_clk);
    check(tag, outv, exp_q.pop_front());
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_rtype(input logic [31:0] instr, input int alu, input string tag);
    i_instr = instr;
    drive(v_fetch(1), 1, 0, {tag, "_fetch"});
    drive(v_decode(0), 0, 0, {tag, "_decode"});
    drive(v_exec(alu, 2'b00, 0), 0, 0, {tag, "_exec"});
    drive(v_alu_wb(1), 0, 0, {tag, "_wb"});
  endtask

  task automatic run_branch(input logic [31:0] instr, input logic z, input bit taken,
                            input string tag);
    i_instr = instr;
    drive(v_fetch(1), 1, z, {tag, "_fetch"});
    drive(v_decode(0), 1, z, {tag, "_decode"});
    drive(mk(1, 1, 2'b00, 0, taken, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0), 1, z, {tag, "_exec"});
  endtask

  initial begin
    @(posedge i_clk);
    #1;
    for (int i = 0; i < 3; i++) drive('0, 1, 0, "reset_hold");
    i_rst = 1'b0;

    run_rtype(32'h00A62020, 0, "add");

    i_instr = 32'h8C820004;
    drive(v_fetch(1), 1, 0, "lw_fetch");
    drive(v_decode(0), 1, 0, "lw_decode");
    drive(v_exec(0, 2'b10, 0), 1, 0, "lw_exec");
    drive(mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0), 0, 0, "lw_rd_wait1");
    drive(mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0), 0, 0, "lw_rd_wait2");
    drive(mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0), 1, 0, "lw_rd_done");
    drive(mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0), 0, 0, "lw_wb");

    run_branch(32'h10850003, 1, 1, "beq_z1");
    run_branch(32'h10850003, 0, 0, "beq_z0");
    run_branch(32'h14850003, 0, 1, "bne_z0");
    run_branch(32'h14850003, 1, 0, "bne_z1");

    i_instr = 32'h34A5FFFF;
    drive(v_fetch(1), 1, 0, "ori_fetch");
    drive(v_decode(0), 1, 0, "ori_decode");
    drive(v_exec(3, 2'b10, 1), 1, 0, "ori_exec");
    drive(v_alu_wb(0), 1, 0, "ori_wb");

    run_rtype(32'h00A6202A, 6, "slt");

    i_instr = 32'h08000010;
    drive(v_fetch(1), 1, 0, "j_fetch");
    drive(v_decode(1), 0, 0, "j_decode");

    i_instr = 32'hACA20008;
    drive(v_fetch(0), 0, 0, "sw_fetch_wait");
    drive(v_fetch(1), 1, 0, "sw_fetch");
    drive(v_decode(0), 1, 0, "sw_decode");
    drive(v_exec(0, 2'b10, 0), 1, 0, "sw_exec");
    drive(mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0), 1, 0, "sw_wr");

    drive(v_fetch(1), 1, 0, "sw2_fetch");
    drive(v_decode(0), 1, 0, "sw2_decode");
    drive(v_exec(0, 2'b10, 0), 1, 0, "sw2_exec");
    i_mem_ready = 1'b0;
    exp_q.push_back(mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0));
    #2;
    check("sw2_wr_before_rst", outv, exp_q.pop_front());
    i_rst = 1'b1;
    exp_q.push_back('0);
    #1;
    check("sw2_wr_abort", outv, exp_q.pop_front());
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    i_instr = 32'hFC000000;
    drive(v_fetch(1), 1, 0, "ill_fetch");
    drive(v_decode(0), 1, 0, "ill_decode");
    for (int i = 0; i < 12; i++)
      drive(mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1), 1, 0, "trap_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
